// File: rtl/debounce_pkg.sv
// Shared state encoding and sizing helpers for the debounce_sync input-conditioning stage.
// Latency and backpressure are described in the modules that use these definitions.
package debounce_pkg;

    localparam int DB_CNT_MAX_DEF = 50000;

    typedef enum logic [1:0] {
        ST_LO      = 2'b00,
        ST_WAIT_HI = 2'b01,
        ST_HI      = 2'b11,
        ST_WAIT_LO = 2'b10
    } db_state_t;

    function automatic int cnt_w(input int cnt_max);
        return $clog2(cnt_max + 1);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One channel: 2-flop synchronizer, then a counter-qualified 4-state debounce FSM (busy port with DB_BUSY_EN).
// Latency CNT_MAX+2 edges from a clean din step to dout; level input, no backpressure.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int CNT_MAX = DB_CNT_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
`ifdef DB_BUSY_EN
    ,
    output logic busy
`endif
);

    localparam int              CNT_W    = cnt_w(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1, s2;
    db_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             rise_nxt, fall_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= ST_LO;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
`ifdef DB_BUSY_EN
            busy  <= 1'b0;
`endif
        end else begin
            s1    <= din;
            s2    <= s1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
`ifdef DB_BUSY_EN
            busy  <= (state_nxt == ST_WAIT_HI) || (state_nxt == ST_WAIT_LO);
`endif
        end
    end

    // cnt holds the number of consecutive s2 samples already seen at the new level
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            ST_LO: begin
                if (s2) begin
                    state_nxt = ST_WAIT_HI;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT_HI: begin
                if (!s2) begin
                    state_nxt = ST_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_HI;
                    cnt_nxt   = '0;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            ST_HI: begin
                if (!s2) begin
                    state_nxt = ST_WAIT_LO;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT_LO: begin
                if (s2) begin
                    state_nxt = ST_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_LO;
                    cnt_nxt   = '0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Accepted level is high in ST_HI and while still qualifying a drop
    assign dout = (state == ST_HI) || (state == ST_WAIT_LO);

endmodule

// File: rtl/debounce_sync.sv
// N_CH independent synchronize+debounce channels feeding the lab gates; busy port only with DB_BUSY_EN.
// Latency CNT_MAX+2 edges din->dout, registered outputs; level inputs, no backpressure.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int N_CH    = 3,
    parameter int CNT_MAX = DB_CNT_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] dout,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
`ifdef DB_BUSY_EN
    ,
    output logic [N_CH-1:0] busy
`endif
);

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        debounce_chan #(
            .CNT_MAX(CNT_MAX)
        ) u_chan (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (din[g]),
            .dout (dout[g]),
            .rise (rise[g]),
            .fall (fall[g])
`ifdef DB_BUSY_EN
            ,
            .busy (busy[g])
`endif
        );
    end

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync with CNT_MAX=4: directed scenarios plus random toggling, checked against
// a run-length model (a level is accepted once it has been seen CNT_MAX times in a row after the 2-edge sync delay).
module tb_debounce_sync;

    localparam int N  = 3;
    localparam int CM = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] din = '0;
    logic [N-1:0] dout, rise, fall;
`ifdef DB_BUSY_EN
    logic [N-1:0] busy;
`endif

    always #5 clk = ~clk;

    debounce_sync #(
        .N_CH   (N),
        .CNT_MAX(CM)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (din),
        .dout (dout),
        .rise (rise),
        .fall (fall)
`ifdef DB_BUSY_EN
        ,
        .busy (busy)
`endif
    );

    // Reference model state
    logic [N-1:0] m_s1, m_s2, m_dout, m_rise, m_fall;
    int           run [N];

    int n_vec = 0;
    int n_err = 0;
    int edge_no = 0;
    int n_rise [N];
    int n_fall [N];
    int n_busy [N];
    int last_rise_edge [N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_no, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1   = '0;
        m_s2   = '0;
        m_dout = '0;
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < N; i++) run[i] = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] seen;
        seen   = m_s2;
        m_s2   = m_s1;
        m_s1   = din;
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < N; i++) begin
            if (seen[i] != m_dout[i]) run[i]++;
            else                      run[i] = 0;
            if (run[i] == CM) begin
                m_dout[i] = seen[i];
                if (seen[i]) m_rise[i] = 1'b1;
                else         m_fall[i] = 1'b1;
                run[i] = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] m_busy;
        chk("dout", 32'(dout), 32'(m_dout));
        chk("rise", 32'(rise), 32'(m_rise));
        chk("fall", 32'(fall), 32'(m_fall));
`ifdef DB_BUSY_EN
        for (int i = 0; i < N; i++) m_busy[i] = (run[i] != 0);
        chk("busy", 32'(busy), 32'(m_busy));
`else
        m_busy = '0;
`endif
    endtask

    task automatic clear_stats();
        for (int i = 0; i < N; i++) begin
            n_rise[i] = 0;
            n_fall[i] = 0;
            n_busy[i] = 0;
            last_rise_edge[i] = -1;
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (rst_n) model_edge();
            else       model_reset();
            edge_no++;
            #1;
            compare_all();
            for (int i = 0; i < N; i++) begin
                if (rise[i]) begin
                    n_rise[i]++;
                    last_rise_edge[i] = edge_no;
                end
                if (fall[i]) n_fall[i]++;
`ifdef DB_BUSY_EN
                if (busy[i]) n_busy[i]++;
`endif
            end
        end
    endtask

    initial begin
        int t0;
        model_reset();
        clear_stats();

        // Reset held with quiet inputs
        rst_n = 1'b0;
        din   = '0;
        step(20);
        rst_n = 1'b1;
        step(3);

        // Clean step on channel 0
        clear_stats();
        t0 = edge_no;
        din[0] = 1'b1;
        step(8);
        chk("clean_rise_edge", 32'(last_rise_edge[0] - t0), 32'(6));
        chk("clean_rise_cnt", 32'(n_rise[0]), 32'(1));

        // 3-cycle glitch on channel 1
        clear_stats();
        din[1] = 1'b1;
        step(3);
        din[1] = 1'b0;
        step(10);
        chk("glitch_rise_cnt", 32'(n_rise[1]), 32'(0));
        chk("glitch_dout", 32'(dout[1]), 32'(0));
`ifdef DB_BUSY_EN
        chk("glitch_busy_cycles", 32'(n_busy[1]), 32'(3));
`endif

        // Bounce on channel 2, then settle high
        clear_stats();
        for (int r = 0; r < 5; r++) begin
            din[2] = 1'b1;
            step(2);
            din[2] = 1'b0;
            step(2);
        end
        t0 = edge_no;
        din[2] = 1'b1;
        step(10);
        chk("bounce_rise_cnt", 32'(n_rise[2]), 32'(1));
        chk("bounce_rise_edge", 32'(last_rise_edge[2] - t0), 32'(6));

        // All channels high, then drop together
        din = 3'b111;
        step(10);
        chk("all_hi_dout", 32'(dout), 32'(3'b111));
        clear_stats();
        din = 3'b000;
        step(5);
        chk("all_lo_pre", 32'(fall), 32'(3'b000));
        step(1);
        chk("all_lo_fall", 32'(fall), 32'(3'b111));
        chk("all_lo_dout", 32'(dout), 32'(3'b000));
        step(4);

        // Reset asserted in the middle of a pending fall
        din = 3'b001;
        step(10);
        chk("pre_rst_dout", 32'(dout), 32'(3'b001));
        din[0] = 1'b0;
        step(4);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_dout", 32'(dout), 32'(3'b000));
        chk("mid_rst_fall", 32'(fall), 32'(3'b000));
        din[0] = 1'b1;
        step(2);
        clear_stats();
        rst_n = 1'b1;
        step(10);
        chk("post_rst_rise_cnt", 32'(n_rise[0]), 32'(1));
        chk("post_rst_fall_cnt", 32'(n_fall[0]), 32'(0));
        chk("post_rst_dout", 32'(dout), 32'(3'b001));

        // Toggle every cycle: level must never be accepted
        clear_stats();
        for (int r = 0; r < 20; r++) begin
            din[1] = ~din[1];
            step(1);
        end
        chk("toggle_rise_cnt", 32'(n_rise[1]), 32'(0));
        din[1] = 1'b0;
        step(6);

        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(5) == 0) din[i] = ~din[i];
            if ($urandom_range(400) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_all();
                step(1 + $urandom_range(2));
                rst_n = 1'b1;
            end
            step(1);
            chk("rise_fall_excl", 32'(rise & fall), 32'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
